// File: rtl/mac_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_collector
// Description : Sums fixed-length groups of 18-bit MAC results and queues each
//               group total in a small result FIFO for a downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_collector #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [17:0]      in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             in_ready,
    output logic             busy,
    output logic             overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [LEN_W-1:0]   w_cfg_eff;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   w_sum_ext;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_push_data;
    logic               w_push;

    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic [c_ptr_w:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_drop;
    logic               r_overflow;
    logic [ACC_W-1:0]   r_mem [DEPTH];

    // A zero length behaves as a group of one
    assign w_cfg_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign w_sum_ext = ACC_W'(in_sum);
    assign w_sum     = r_acc + w_sum_ext;
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    // ------------------------------------------------------------------------
    // Group accumulator state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= LEN_W'(1);
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_push      = 1'b0;
        w_push_data = w_sum;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_cfg_eff == LEN_W'(1)) begin
                        w_push      = 1'b1;
                        w_push_data = w_sum_ext;
                    end else begin
                        w_len_nxt   = w_cfg_eff;
                        w_acc_nxt   = w_sum_ext;
                        w_cnt_nxt   = LEN_W'(1);
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    if (w_cnt_inc == r_len) begin
                        // Final beat: the total leaves even if the FIFO drops it
                        w_push      = 1'b1;
                        w_push_data = w_sum;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_acc_nxt   = w_sum;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_push      = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == (c_ptr_w + 1)'(DEPTH));
    assign w_empty = (w_count == '0);
    assign w_pop   = !w_empty && out_ready && !clear;
    // When full, a simultaneous pop frees the slot the push reuses
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_acc   = w_empty ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign in_ready  = !w_full;
    assign busy      = (r_cnt != '0);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 The module SHALL have parameter LEN_W, default 8, meaning the width of the group-length field.
REQ-002 The module SHALL have parameter ACC_W, default 32, meaning the accumulator and result width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, at least 2).
REQ-004 The module SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  meaning reset, asynchronous assert and active-low.
REQ-006 The module SHALL have port clear  input  1  meaning synchronous flush of the accumulator, counter, FIFO and overflow flag.
REQ-007 The module SHALL have port cfg_len  input  LEN_W  meaning MAC results per group; 0 is treated as 1.
REQ-008 The module SHALL have port in_valid  input  1  meaning an 18-bit MAC result is present this cycle; there is no backpressure.
REQ-009 The module SHALL have port in_sum  input  18  meaning the unsigned MAC result.
REQ-010 The module SHALL have port out_valid  output  1  meaning the FIFO head holds a group result.
REQ-011 The module SHALL have port out_ready  input  1  meaning the consumer accepts the FIFO head.
REQ-012 The module SHALL have port out_acc  output  ACC_W  meaning the group sum at the FIFO head.
REQ-013 The module SHALL have port in_ready  output  1  meaning advisory: the FIFO has at least one free entry.
REQ-014 The module SHALL have port busy  output  1  meaning a group is partially accumulated (counter not zero).
REQ-015 The module SHALL have port overflow  output  1  meaning sticky: a completed group was dropped.

Function
REQ-016 The module SHALL use two states: IDLE (counter == 0) and ACCUM (counter > 0).
REQ-017 In IDLE, in_valid SHALL latch the effective length L = max(cfg_len, 1) and load acc = in_sum.
REQ-018 A cfg_len change SHALL be ignored until the next group starts.
REQ-019 In ACCUM, each in_valid SHALL add in_sum, zero-extended to ACC_W, to acc modulo 2^ACC_W.
REQ-020 Each in_valid SHALL increment the counter by 1.
REQ-021 The in_valid that makes the count equal L SHALL push acc + in_sum into the FIFO.
REQ-022 That final in_valid SHALL return the block to IDLE with acc = 0 and counter = 0 on the same edge.
REQ-023 When L = 1, every in_valid SHALL push in_sum directly and the block SHALL remain in IDLE.
REQ-024 Cycles without in_valid SHALL hold acc and the counter; gaps between results are allowed.
REQ-025 A pushed result SHALL appear with out_valid high on the cycle after the final in_valid edge (1-cycle latency).
REQ-026 A pop SHALL occur when out_valid && out_ready.
REQ-027 out_acc and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-028 Results SHALL be popped in first-in, first-out order.
REQ-029 A push with the FIFO full and a pop in the same cycle SHALL succeed, with the occupancy unchanged.
REQ-030 A push with the FIFO full and no pop SHALL drop the result and set overflow.
REQ-031 A dropped push SHALL still reset acc and the counter.
REQ-032 A push and a pop on an empty FIFO SHALL not bypass: the push is visible on the next cycle.
REQ-033 in_ready SHALL equal (occupancy < DEPTH), driven combinationally from registered occupancy.
REQ-034 overflow SHALL stay high until clear or reset.
REQ-035 clear SHALL override in_valid and out_ready in the same cycle.
REQ-036 After clear, the next cycle SHALL show out_valid = 0, busy = 0, overflow = 0, acc = 0 and counter = 0.
REQ-037 in_valid arriving the cycle after clear SHALL start a new group.

Reset
REQ-038 While rst_n = 0, the block SHALL asynchronously set out_valid = 0, out_acc = 0, in_ready = 1, busy = 0 and overflow = 0.
REQ-039 While rst_n = 0, the block SHALL asynchronously set acc = 0, counter = 0, latched L = 1 and FIFO pointers = 0.
REQ-040 Reset SHALL discard a partial group in progress.
REQ-041 The first in_valid after rst_n deasserts SHALL start a new group.

Verification
REQ-042 The bench SHALL cover: cfg_len=4, in_sum 100, 200, 300, 400 back-to-back, out_ready=1 -> one out_acc=1000, out_valid one cycle after the 4th input.
REQ-043 The bench SHALL cover: cfg_len=0, in_sum 5 then 7 -> two results, 5 then 7, busy never asserted.
REQ-044 The bench SHALL cover: cfg_len=1, out_ready=0, DEPTH+1 inputs of 1..5 -> FIFO holds 1..4, in_ready=0 after 4, 5th dropped, overflow=1, then pops return 1,2,3,4.
REQ-045 The bench SHALL cover: cfg_len=3, inputs 0x3FFFF with idle gaps, cfg_len changed to 2 mid-group -> out_acc=0xBFFFD, next group uses L=2.
REQ-046 The bench SHALL cover: FIFO full, out_ready=1 and a final in_valid in the same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-047 The bench SHALL cover: rst_n pulled low, then separately clear, after 2 of 4 inputs -> partial sum discarded, next 4 inputs of 1 yield out_acc=4.
